// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions.
// Holds the 3-bit opcode encoding used by the requesters and the ALU
// datapath, plus a helper that tells legal opcodes from reserved ones.
package alu_pkg;

  localparam int OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_ADD = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_AND = 3'b010;
  localparam logic [OP_WIDTH-1:0] OP_OR  = 3'b011;
  localparam logic [OP_WIDTH-1:0] OP_XOR = 3'b100;

  // Opcodes 101..111 are reserved.
  function automatic logic is_legal_op(input logic [OP_WIDTH-1:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response bundle of the shared-ALU arbiter.
//
// Handshake rules (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high for the same requester. A requester
// holds its request fields stable while valid is high and ready is low.
// req_ready may depend combinationally on req_valid and rsp_ready; rsp_valid
// is a registered one-hot owner marker and the response fields stay stable
// while rsp_valid is high and the owner's rsp_ready is low.
//
// Signals:
//   req_valid/req_ready  per-requester request handshake
//   req_a/req_b          packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_op               packed opcodes, requester i at [i*3 +: 3]
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_result, rsp_zero, rsp_overflow, rsp_illegal  held result and flags
//   ops_done             completed response handshakes (wraps)
interface alu_share_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]                      req_valid;
  logic [NUM_REQ-1:0]                      req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0]           req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0]           req_b;
  logic [NUM_REQ*alu_pkg::OP_WIDTH-1:0]    req_op;
  logic [NUM_REQ-1:0]                      rsp_valid;
  logic [NUM_REQ-1:0]                      rsp_ready;
  logic [DATA_WIDTH-1:0]                   rsp_result;
  logic                                    rsp_zero;
  logic                                    rsp_overflow;
  logic                                    rsp_illegal;
  logic [CNT_WIDTH-1:0]                    ops_done;

  // Requester side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
           rsp_illegal, ops_done
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
           rsp_illegal, ops_done
  );
endinterface

// File: rtl/alu_share_arb_alu.sv
// alu: 32-bit (parameterisable) combinational ALU datapath.
// Ports:
//   a, b      operands
//   op        opcode (alu_pkg encoding); reserved opcodes give result 0
//   result    operation result, two's-complement modulo 2^DATA_WIDTH
//   zero      result == 0
//   overflow  signed overflow for ADD/SUB, 0 for logic ops
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  overflow
);
  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum;
        // Same-sign operands producing an opposite-sign sum.
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result   = diff;
        // Different-sign operands where the result sign differs from a.
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one ALU between NUM_REQ requesters.
// A single registered output stage holds the result for its owner; a new
// request can be accepted in the same cycle the held result drains, giving
// one operation per cycle and one cycle of latency.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   alu_share_arb_if slave modport (request/response channels,
//         held result/flags, ops_done counter)
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  alu_share_arb_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] idx_t;

  idx_t                  ptr;
  idx_t                  owner;
  idx_t                  grant_idx;
  idx_t                  cand;
  logic [PTR_W:0]        cand_sum;
  logic                  found;
  logic                  out_full;
  logic                  drain;
  logic                  can_accept;
  logic                  accept;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [OP_WIDTH-1:0]   op_sel;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_ovf;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  ovf_q;
  logic                  illegal_q;
  logic [CNT_WIDTH-1:0]  ops_done_q;

  // Owner of the held result: index of the single set bit of rsp_valid.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid_q[i]) owner = idx_t'(i);
    end
  end

  assign out_full   = |rsp_valid_q;
  assign drain      = out_full & bus.rsp_ready[owner];
  assign can_accept = !out_full | drain;

  // Round-robin search: candidates ptr, ptr+1, ... wrapping modulo NUM_REQ.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ)) cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      cand = cand_sum[PTR_W-1:0];
      if (!found && bus.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept = can_accept & found;

  always_comb begin
    grant_oh = '0;
    if (accept) grant_oh[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant_oh;

  // Operand mux for the granted requester.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == idx_t'(i)) begin
        op_a   = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        op_b   = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
        op_sel = bus.req_op[i*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (op_sel),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  assign illegal = !is_legal_op(op_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      ops_done_q  <= '0;
      ptr         <= '0;
    end else begin
      if (accept) begin
        rsp_valid_q <= grant_oh;
        // Reserved opcodes answer with a fixed zero result.
        result_q    <= illegal ? '0   : alu_result;
        zero_q      <= illegal ? 1'b1 : alu_zero;
        ovf_q       <= illegal ? 1'b0 : alu_ovf;
        illegal_q   <= illegal;
        ptr         <= (grant_idx == idx_t'(NUM_REQ-1)) ? '0 : grant_idx + idx_t'(1);
      end else if (drain) begin
        rsp_valid_q <= '0;
      end
      if (drain) ops_done_q <= ops_done_q + CNT_WIDTH'(1);
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_illegal  = illegal_q;
  assign bus.ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: randomized scoreboard bench for alu_share_arb.
module tb_alu_share_arb;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int CW = 4;
  localparam int EW = DW + 3;
  localparam int JW = 2*DW + 3;
  localparam int IDLE_LIMIT = 5000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  alu_share_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packs {illegal, overflow, zero, result}.
  function automatic logic [EW-1:0] ref_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] op);
    longint sa, sb, s;
    longint lim_hi, lim_lo;
    logic [DW-1:0] r;
    logic ov, il;
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    r  = '0;
    ov = 1'b0;
    il = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = s[DW-1:0]; ov = (s > lim_hi) || (s < lim_lo); end
      3'd1: begin s = sa - sb; r = s[DW-1:0]; ov = (s > lim_hi) || (s < lim_lo); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: il = 1'b1;
    endcase
    return {il, ov, (r == '0), r};
  endfunction

  // ---------------- driver ----------------
  logic [NR-1:0] v;
  logic [DW-1:0] a_r  [NR];
  logic [DW-1:0] b_r  [NR];
  logic [2:0]    op_r [NR];
  logic [NR-1:0] rsp_rdy;
  logic [JW-1:0] job_q [NR][$];
  logic [EW-1:0] exp_q [NR][$];
  int            grant_log[$];
  int            rdy_mode = 0;       // 0: always ready, 1: random, 2: rdy_force
  logic [NR-1:0] rdy_force = '0;
  int            gap_pct = 0;

  always_comb begin
    bus.req_valid = v;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*DW +: DW] = a_r[i];
      bus.req_b[i*DW +: DW] = b_r[i];
      bus.req_op[i*3 +: 3]  = op_r[i];
    end
  end
  assign bus.rsp_ready = rsp_rdy;

  task automatic push_job(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2:0] op);
    job_q[i].push_back({a, b, op});
  endtask

  initial begin
    logic [NR-1:0] acc;
    logic [JW-1:0] j;
    v       = '0;
    rsp_rdy = '0;
    for (int i = 0; i < NR; i++) begin
      a_r[i] = '0; b_r[i] = '0; op_r[i] = '0;
    end
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: rsp_rdy = '1;
        1: for (int i = 0; i < NR; i++) rsp_rdy[i] = ($urandom_range(0, 9) < 7);
        default: rsp_rdy = rdy_force;
      endcase
      #1;
      acc = v & bus.req_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        v = '0;
        for (int i = 0; i < NR; i++) job_q[i].delete();
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (acc[i]) v[i] = 1'b0;
          if (!v[i] && job_q[i].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
            j       = job_q[i].pop_front();
            a_r[i]  = j[JW-1 -: DW];
            b_r[i]  = j[3 +: DW];
            op_r[i] = j[2:0];
            v[i]    = 1'b1;
            exp_q[i].push_back(ref_model(a_r[i], b_r[i], op_r[i]));
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [NR-1:0] prev_acc, prev_valid, acc_now, exp_rdy;
    logic          prev_drain, owner_drain, may_accept;
    logic [EW-1:0] prev_data, cur_data, e;
    int            last_grant, mdl_cnt, idx;
    prev_acc = '0; prev_valid = '0; prev_drain = 1'b0; prev_data = '0;
    last_grant = NR - 1; mdl_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        for (int i = 0; i < NR; i++) exp_q[i].delete();
        prev_acc = '0; prev_valid = '0; prev_drain = 1'b0; prev_data = '0;
        last_grant = NR - 1; mdl_cnt = 0;
        continue;
      end
      cur_data = {bus.rsp_illegal, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result};
      // Output stage: loads on accept, clears on drain, otherwise holds.
      if (prev_acc != '0) begin
        check("rsp_valid_after_accept", bus.rsp_valid, prev_acc);
      end else begin
        if (prev_drain) check("rsp_valid_after_drain", bus.rsp_valid, '0);
        else            check("rsp_valid_hold", bus.rsp_valid, prev_valid);
        check("rsp_data_hold", cur_data, prev_data);
      end
      check("rsp_valid_onehot0", $onehot0(bus.rsp_valid), 1);
      check("ops_done", bus.ops_done, mdl_cnt % (1 << CW));
      // Grant: first valid requester after the last one granted.
      owner_drain = |(bus.rsp_valid & bus.rsp_ready);
      may_accept  = (bus.rsp_valid == '0) || owner_drain;
      exp_rdy     = '0;
      if (may_accept) begin
        for (int k = 0; k < NR; k++) begin
          idx = (last_grant + 1 + k) % NR;
          if (bus.req_valid[idx] && exp_rdy == '0) exp_rdy[idx] = 1'b1;
        end
      end
      check("req_ready", bus.req_ready, exp_rdy);
      // Response handshakes against the per-requester expected queues.
      for (int i = 0; i < NR; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("rsp_unexpected_%0d", i), 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("rsp_data_%0d", i), cur_data, e);
          end
          mdl_cnt++;
        end
      end
      acc_now = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NR; i++) begin
        if (acc_now[i]) begin
          last_grant = i;
          grant_log.push_back(i);
        end
      end
      prev_acc = acc_now; prev_drain = owner_drain;
      prev_valid = bus.rsp_valid; prev_data = cur_data;
    end
  end

  // ---------------- main sequence ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
  endtask

  function automatic bit all_idle();
    bit r;
    r = (v == '0) && (bus.rsp_valid == '0);
    for (int i = 0; i < NR; i++) r = r && job_q[i].size() == 0 && exp_q[i].size() == 0;
    return r;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #3; n++;
    end while (!all_idle() && n < IDLE_LIMIT);
    check({name, "_idle_timeout"}, (n >= IDLE_LIMIT), 0);
  endtask

  task automatic wait_valid(input logic [NR-1:0] pat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #3; n++;
    end while (bus.rsp_valid != pat && n < 200);
    check({name, "_wait_timeout"}, (n >= 200), 0);
  endtask

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    do_reset();

    // Reset then idle.
    repeat (2) @(negedge clk);
    #3;
    check("reset_rsp_valid", bus.rsp_valid, '0);
    check("reset_rsp_result", bus.rsp_result, '0);
    check("reset_ops_done", bus.ops_done, '0);
    check("reset_req_ready", bus.req_ready, '0);
    check("reset_rsp_illegal", bus.rsp_illegal, 1'b0);

    // Single ADD with signed overflow.
    push_job(0, 32'h7FFF_FFFF, 32'h1, 3'b000);
    wait_idle("single");
    check("single_ops_done", bus.ops_done, 1);
    check("single_result", bus.rsp_result, 32'h8000_0000);
    check("single_overflow", bus.rsp_overflow, 1'b1);
    check("single_zero", bus.rsp_zero, 1'b0);

    // Contention fairness from reset.
    do_reset();
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      push_job(0, 32'd5, 32'd5, 3'b001);
      push_job(1, 32'hF0F0_F0F0, 32'hFFFF_0000, 3'b100);
    end
    wait_idle("fair");
    check("fair_grant_count", grant_log.size(), 8);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("fair_grant_%0d", k), grant_log[k], k % 2);
    check("fair_last_result", bus.rsp_result, 32'h0F0F_F0F0);

    // Backpressure from owner 1 while requester 0 waits.
    rdy_mode  = 2;
    rdy_force = '0;
    push_job(1, 32'd1, 32'd2, 3'b000);
    wait_valid(2'b10, "bp_owner");
    push_job(0, 32'd3, 32'd4, 3'b011);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #3;
      check("bp_req_ready", bus.req_ready, 2'b00);
      check("bp_rsp_valid", bus.rsp_valid, 2'b10);
      check("bp_rsp_result", bus.rsp_result, 32'd3);
    end
    rdy_force = 2'b10;
    @(negedge clk); #3;
    check("bp_release_grant", bus.req_ready, 2'b01);
    @(negedge clk); #3;
    check("bp_next_owner", bus.rsp_valid, 2'b01);
    check("bp_next_result", bus.rsp_result, 32'd7);
    rdy_mode = 0;
    wait_idle("bp");

    // Illegal opcode.
    push_job(0, 32'd5, 32'd3, 3'b110);
    wait_idle("illegal");
    check("illegal_flag", bus.rsp_illegal, 1'b1);
    check("illegal_result", bus.rsp_result, '0);
    check("illegal_zero", bus.rsp_zero, 1'b1);
    check("illegal_overflow", bus.rsp_overflow, 1'b0);

    // Mid-operation reset discards the held result.
    rdy_mode  = 2;
    rdy_force = '0;
    push_job(1, 32'd9, 32'd9, 3'b000);
    wait_valid(2'b10, "midrst");
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, '0);
    check("midrst_result", bus.rsp_result, '0);
    check("midrst_ops_done", bus.ops_done, '0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    rdy_mode = 0;

    // Counter wrap: 17 completions on a 4-bit counter.
    for (int k = 0; k < 17; k++)
      push_job(0, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    wait_idle("wrap");
    check("wrap_ops_done", bus.ops_done, 1);

    // Randomized traffic with random response backpressure and gaps.
    rdy_mode = 1;
    gap_pct  = 30;
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < NR; i++)
        push_job(i, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    end
    wait_idle("random");
    check("random_ops_done", bus.ops_done, (17 + 150*NR) % (1 << CW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Shares one instance of the 32-bit combinational ALU (ADD/SUB/AND/OR/XOR with zero and overflow flags) between NUM_REQ requesters.
- Arbitration is round-robin.
- Each requester has its own valid/ready request channel and its own valid/ready response channel.
- A single registered output stage gives 1-cycle latency and a throughput of one operation per cycle.
- The block sits between the issue logic of several pipeline clients and the shared ALU datapath.

Parameters:
DATA_WIDTH, 32, operand/result width passed to the ALU.
NUM_REQ, 2, number of requesters (legal range 2..8).
CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester request accepted (one-hot or zero).
req_a  input  NUM_REQ*DATA_WIDTH  operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_b  input  NUM_REQ*DATA_WIDTH  operand B; same packing as req_a.
req_op  input  NUM_REQ*3  opcode; requester i occupies bits [i*3 +: 3].
rsp_valid  output  NUM_REQ  one-hot; marks the owner of the held result.
rsp_ready  input  NUM_REQ  per-requester response accept.
rsp_result  output  DATA_WIDTH  held result.
rsp_zero  output  1  held zero flag.
rsp_overflow  output  1  held overflow flag.
rsp_illegal  output  1  held opcode was not 000..100.
ops_done  output  CNT_WIDTH  count of completed response handshakes; wraps.

Behaviour:
- Reset (asynchronous, takes effect immediately) clears:
  - rsp_valid = 0
  - rsp_result = 0, rsp_zero = 0, rsp_overflow = 0, rsp_illegal = 0
  - ops_done = 0
  - round-robin pointer = 0, so requester 0 has top priority on the first grant.
- Reset asserted mid-operation discards the held result; no response handshake is produced for it.
- Output stage state: out_full = |rsp_valid. The owner is the index of the set bit in rsp_valid.
- Drain: drain = out_full & rsp_ready[owner]. rsp_ready on non-owner lines is ignored.
- Accept enable: can_accept = !out_full | drain. New work may be accepted in the same cycle the held result drains.
- Grant selection:
  - Search req_valid starting at the pointer and wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready = one-hot grant when can_accept is 1 and any req_valid is set; otherwise req_ready = 0.
  - req_ready may depend combinationally on req_valid and rsp_ready.
- On accept (req_valid[g] & req_ready[g]):
  - Drive the ALU with slice g of req_a, req_b and req_op.
  - Next edge registers result, zero, overflow and illegal.
  - rsp_valid becomes one-hot at bit g.
  - Pointer becomes (g+1) mod NUM_REQ.
- On drain without accept: rsp_valid goes to 0 and the output data holds its last value.
- When no accept occurs, the pointer is unchanged.
- Latency: accepted in cycle N, rsp_valid is high in cycle N+1.
- Backpressure: while out_full & !drain, req_ready = 0 and the response outputs are stable.
- Requester protocol: a requester must hold its request stable while req_valid & !req_ready.
- Arithmetic and flag rules:
  - ADD and SUB are two's-complement modulo 2^DATA_WIDTH.
  - Overflow is signed overflow, for ADD and SUB only; it is 0 for logic ops.
  - zero = (result == 0).
  - An illegal opcode (101..111) is still accepted and answered: result 0, zero 1, overflow 0, illegal 1.
- ops_done increments by 1 on each drain and wraps from all-ones to 0.
- Simultaneous drain and accept in the same cycle:
  - ops_done increments.
  - The output register reloads.
  - rsp_valid moves to the new owner with no bubble.
- A single active requester may issue back-to-back and reaches 1 op/cycle if it holds rsp_ready high.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100
  - OP_WIDTH=3
  - function is_legal_op.
- One sub-module, the existing alu datapath, instantiated once with DATA_WIDTH. The illegal-op override of result and flags is applied in this block, not inside alu.
- Round-robin grant logic stays inline; do not split it into a separate module.

Test Plan:
1. Reset then idle: hold rst, release, no requests -> all rsp_valid=0, rsp_result=0, ops_done=0, req_ready=0.
2. Single op: req 0 sends a=0x7FFFFFFF, b=1, op=ADD, with rsp_ready=1 -> next cycle rsp_valid=01, result=0x80000000, overflow=1, zero=0; ops_done=1.
3. Contention fairness: both requesters valid continuously with SUB 5-5 and XOR 0xF0F0F0F0^0xFFFF0000, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; req 0 sees result 0 with zero=1; req 1 sees 0x0F0FF0F0.
4. Backpressure: owner 1 holds rsp_ready=0 for 3 cycles while req 0 is valid -> req_ready=00, response outputs stable for those 3 cycles; on the cycle rsp_ready[1]=1, req 0 is granted in that same cycle and rsp_valid=01 the next cycle.
5. Illegal op: op=3'b110, a=5, b=3 -> result 0, zero=1, overflow=0, rsp_illegal=1, handshake completes normally.
6. Mid-operation reset and counter wrap: assert rst while rsp_valid=10 -> rsp_valid=0 immediately. Separately, with CNT_WIDTH=4 complete 17 ops -> ops_done=1.
